// File: rtl/mul_result_bcd_pkg.sv
// ---------------------------------------------------------------------------
// mul_result_bcd_pkg
// Shared definitions for the multiplier-result BCD converter:
//   - state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   - BCD_DIGIT_W    : bits per BCD digit
//   - ADD3_THRESHOLD : digit value at or above which the double-dabble
//                      correction (+3) is applied before a shift
//   - cnt_width()    : width of a counter that must hold 0..w inclusive
// ---------------------------------------------------------------------------
package mul_result_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int ADD3_THRESHOLD = 5;

    // Bits needed to represent every value from 0 to w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_result_bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: a BCD digit that is 5 or
// more gets 3 added, so that the following left shift carries correctly
// into the next decimal digit.
//   i_digit : input  [3:0]  BCD digit before correction
//   o_digit : output [3:0]  corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import mul_result_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        if (i_digit >= BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
            o_digit = i_digit + BCD_DIGIT_W'(3);
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/mul_result_bcd.sv
// ---------------------------------------------------------------------------
// mul_result_bcd
// Converts each unsigned binary product from the add-shift multiplier into
// packed BCD using a sequential double-dabble engine (one shift per clock).
// The last converted value is held on bcd for the display driver, and one
// product arriving while the engine is busy is buffered in a pending slot.
//
// Ports:
//   clk       : input                system clock, rising edge
//   rst       : input                asynchronous active-high reset
//   valid     : input                one-cycle pulse, result sampled when high
//   result    : input  [WIDTH-1:0]   unsigned binary product
//   bcd       : output [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
//   bcd_valid : output               one-cycle pulse, bcd updated this cycle
//   busy      : output               converting or pending slot occupied
//   overrun   : output               sticky, a buffered product was lost
// ---------------------------------------------------------------------------
module mul_result_bcd
    import mul_result_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [WIDTH-1:0]              result,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          bcd_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SW    = WIDTH + BCD_W;   // scratch: BCD field above binary
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [SW-1:0]      r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_pend_data;
    logic               r_pend_flag;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_bcd_valid;
    logic               r_overrun;

    logic [SW-1:0]      w_adjusted;
    logic [SW-1:0]      w_shifted;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_val;
    logic               w_last_shift;
    logic               w_pend_write;
    logic               w_pend_take;
    logic               w_overrun_set;

    // Correct every BCD digit of the scratch, then shift the whole word.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[WIDTH + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adjusted[WIDTH + gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_adjusted[WIDTH-1:0] = r_scratch[WIDTH-1:0];
    assign w_shifted             = w_adjusted << 1;

    // Next-state and converter load control.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = result;
        w_last_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_count == CNT_W'(1)) begin
                    w_last_shift = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // The buffered product is older, so it goes first.
                if (r_pend_flag) begin
                    w_load       = 1'b1;
                    w_load_val   = r_pend_data;
                    w_state_next = ST_SHIFT;
                end else if (valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A valid not taken straight into the converter lands in the slot.
    // Overrun only when the slot is full and nobody drains it this cycle.
    always_comb begin
        w_pend_take   = (r_state == ST_DONE) && r_pend_flag;
        w_pend_write  = valid && !((r_state == ST_IDLE) ||
                                   ((r_state == ST_DONE) && !r_pend_flag));
        w_overrun_set = w_pend_write && r_pend_flag && !w_pend_take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scratch   <= '0;
            r_count     <= '0;
            r_pend_data <= '0;
            r_pend_flag <= 1'b0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_load) begin
                r_scratch <= {{BCD_W{1'b0}}, w_load_val};
                r_count   <= CNT_W'(WIDTH);
            end else if (r_state == ST_SHIFT) begin
                r_scratch <= w_shifted;
                r_count   <= r_count - CNT_W'(1);
            end

            // bcd only ever takes the finished field, never partial results.
            if (w_last_shift) begin
                r_bcd <= w_shifted[SW-1 -: BCD_W];
            end
            r_bcd_valid <= w_last_shift;

            if (w_pend_write) begin
                r_pend_data <= result;
                r_pend_flag <= 1'b1;
            end else if (w_pend_take) begin
                r_pend_flag <= 1'b0;
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign busy      = (r_state != ST_IDLE) | r_pend_flag;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_mul_result_bcd.sv
// ---------------------------------------------------------------------------
// tb_mul_result_bcd
// Directed-vector bench for mul_result_bcd (WIDTH=8, DIGITS=3). Inputs are
// driven on the falling edge, outputs sampled on the falling edge after the
// rising edge of interest.
// ---------------------------------------------------------------------------
module tb_mul_result_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  result;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .result    (result),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // One rising edge, then settle on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a product for exactly one rising edge (that edge is E0).
    task automatic put(input logic [7:0] v);
        valid  = 1'b1;
        result = v;
        tick();
        valid  = 1'b0;
    endtask

    task automatic do_reset();
        valid  = 1'b0;
        result = '0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        @(negedge clk);
    endtask

    // Single isolated conversion with timing checks around E8.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp, input logic [11:0] prev);
        logic seen;
        seen = 1'b0;
        put(v);
        check($sformatf("busy_after_E0_%0d", v), busy, 1);
        repeat (6) begin
            tick();
            seen |= bcd_valid;
        end
        tick();                                   // E7
        seen |= bcd_valid;
        check($sformatf("no_early_valid_%0d", v), seen, 0);
        check($sformatf("bcd_held_E7_%0d", v), bcd, prev);
        tick();                                   // E8
        check($sformatf("bcd_E8_%0d", v), bcd, exp);
        check($sformatf("bcd_valid_E8_%0d", v), bcd_valid, 1);
        tick();                                   // E9
        check($sformatf("bcd_valid_E9_%0d", v), bcd_valid, 0);
        check($sformatf("busy_E9_%0d", v), busy, 0);
        check($sformatf("bcd_stable_E9_%0d", v), bcd, exp);
        check($sformatf("overrun_%0d", v), overrun, 0);
    endtask

    initial begin
        logic seen;
        rst    = 1'b1;
        valid  = 1'b0;
        result = '0;
        do_reset();

        check("rst_bcd", bcd, 0);
        check("rst_bcd_valid", bcd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        convert(8'd0,   12'h000, 12'h000);
        convert(8'd225, 12'h225, 12'h000);
        convert(8'd255, 12'h255, 12'h225);
        convert(8'd9,   12'h009, 12'h255);

        // 42 at E0, 100 at E3 -> buffered and converted right after.
        put(8'd42);                               // E0
        tick(); tick();                           // E1, E2
        put(8'd100);                              // E3
        check("pend_busy_E3", busy, 1);
        repeat (5) tick();                        // E4..E8
        check("b2b_bcd_E8", bcd, 12'h042);
        check("b2b_valid_E8", bcd_valid, 1);
        repeat (8) tick();                        // E9..E16
        check("b2b_hold_E16", bcd, 12'h042);
        check("b2b_novalid_E16", bcd_valid, 0);
        tick();                                   // E17
        check("b2b_bcd_E17", bcd, 12'h100);
        check("b2b_valid_E17", bcd_valid, 1);
        tick();                                   // E18
        check("b2b_busy_E18", busy, 0);
        check("b2b_overrun", overrun, 0);

        // 10@E0, 20@E2, 30@E4 -> 20 lost, overrun sticky.
        put(8'd10);                               // E0
        tick();                                   // E1
        put(8'd20);                               // E2
        check("ovr_clear_E2", overrun, 0);
        tick();                                   // E3
        put(8'd30);                               // E4
        check("ovr_set_E4", overrun, 1);
        repeat (4) tick();                        // E5..E8
        check("ovr_bcd_E8", bcd, 12'h010);
        repeat (9) tick();                        // E9..E17
        check("ovr_bcd_E17", bcd, 12'h030);
        check("ovr_valid_E17", bcd_valid, 1);
        tick();                                   // E18
        check("ovr_busy_E18", busy, 0);
        check("ovr_sticky_E18", overrun, 1);

        // Reset in the middle of converting 77.
        put(8'd77);                               // E0
        repeat (3) tick();                        // E1..E3
        rst = 1'b1;
        #1;
        check("midrst_bcd", bcd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= bcd_valid;
        end
        check("midrst_no_valid", seen, 0);
        convert(8'd77, 12'h077, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_result_bcd.md
Name: mul_result_bcd

Overview:
- Downstream consumer of the add-shift multiplier's `result`/`valid` output.
- Converts each unsigned binary product to packed BCD with a sequential double-dabble (shift-and-add-3) engine, for the FPGA display path.
- Holds the last converted value stable for the display driver.
- Buffers one product that arrives while a conversion is in progress.

Parameters:
- WIDTH, 8, bit width of the binary input (the multiplier product width).
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- valid  input  1  one-cycle pulse from the multiplier; `result` is sampled when high.
- result  input  WIDTH  unsigned binary product.
- bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0]; holds until the next completion.
- bcd_valid  output  1  one-cycle pulse; `bcd` was updated this cycle.
- busy  output  1  high while converting or while the pending slot is occupied.
- overrun  output  1  sticky; a buffered input was overwritten. Cleared only by `rst`.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; shift register, counter, pending slot and pending flag cleared.
  - `bcd`=0, `bcd_valid`=0, `busy`=0, `overrun`=0.
  - Reset mid-conversion abandons the conversion; no `bcd_valid` follows.
- Internal scratch is WIDTH+4*DIGITS bits: BCD field in the upper bits, binary in the lower bits. Counter counts WIDTH down to 0.
- State machine, states IDLE, SHIFT, DONE:
  - IDLE: if `valid` is sampled high at edge E0, load binary=`result`, clear the BCD field, set counter=WIDTH, go to SHIFT.
  - SHIFT: on each edge, first add 3 to every BCD digit that is >=5, then shift the whole scratch left by 1 and decrement the counter.
    - The edge performing the WIDTH-th shift registers the final BCD field into `bcd` and goes to DONE.
  - DONE: lasts exactly 1 cycle, with `bcd_valid`=1. On the next edge:
    - if the pending slot is full, load it (priority over a new input), clear the pending flag, go to SHIFT;
    - else if `valid` is high, load `result`, go to SHIFT;
    - else go to IDLE.
- Latency:
  - Input sampled at E0 gives `bcd`/`bcd_valid` visible after edge E0+WIDTH (8 for the defaults).
  - Back-to-back conversions run every WIDTH+1 cycles.
- Pending slot (depth 1):
  - A `valid` that is not consumed directly is written to the slot. This covers `valid` during SHIFT, and `valid` during DONE while the slot is full.
  - Slot full and a new `valid` not consumed in the same cycle: overwrite the slot with the new value and set `overrun`=1.
  - DONE with slot full and `valid` high: the slot value moves into the converter, the new value enters the slot, and `overrun` is not set.
- `busy` = (state != IDLE) | pending_flag, registered-equivalent (no glitch on inputs).
- `bcd` never shows intermediate values; it changes only on the edge entering DONE.
- Inputs with value 0 and the maximum value 2^WIDTH-1 need no special handling.

Decomposition:
- Shared package contents:
  - state encoding localparams (IDLE, SHIFT, DONE);
  - BCD_DIGIT_W = 4;
  - ADD3_THRESHOLD = 5;
  - a function computing the counter width, clog2(WIDTH+1).
- One natural sub-module, `bcd_digit_adj`: combinational 4-bit "if >=5 add 3", instantiated DIGITS times by a generate loop.

Test Plan:
- Reset, then `valid` with `result`=0 -> after 8 edges `bcd`=12'h000, `bcd_valid` high for 1 cycle, `busy` low the following cycle.
- `result`=225 (15*15) -> `bcd`=12'h225 exactly 8 edges after sampling; `bcd` stable until the next completion.
- `result`=255 and `result`=9 in separate runs -> 12'h255 and 12'h009; `overrun` stays 0.
- `valid`=42 at E0, then `valid`=100 at E3 -> `bcd`=12'h042 at E8, `bcd`=12'h100 at E17, `busy` low after E18, `overrun`=0.
- Inputs 10@E0, 20@E2, 30@E4 -> 12'h010 then 12'h030; 20 is never output; `overrun`=1 from E4 until `rst`.
- Assert `rst` at E4 of a conversion of 77 -> `bcd`=0 and `busy`=0 immediately; no `bcd_valid` afterwards. A new input of 77 converts to 12'h077 normally.
